bit_serializer: RTL
===================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the FSM sequence detector (seq_detector).
//  Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one
//  bit per enabled clock on bit_out, which drives the detector's bit_in.
//  Supports back-to-back words with no idle gap, plus a downstream advance
//  enable for rate control.
// PARAMETERS
//  WIDTH      8   word width in bits, >= 2
//  MSB_FIRST  1   1: transmit bit WIDTH-1 first; 0: transmit bit 0 first
//  IDLE_BIT   0   level driven on bit_out while no word is in flight
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous reset, active-low
//  data_in       in   WIDTH  parallel word to serialize
//  data_valid    in   1      data_in holds a valid word
//  data_ready    out  1      block can accept data_in this cycle
//  bit_en        in   1      downstream consumes current bit and advances this cycle
//  bit_out       out  1      current serial bit
//  bit_valid     out  1      bit_out carries word data
//  last_bit      out  1      bit_out is the final bit of the current word
//  busy          out  1      word in flight (state SHIFT)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, shift_reg=0, cnt=0. Outputs are
//    bit_out=IDLE_BIT, bit_valid=0, last_bit=0, busy=0, and data_ready=0
//    while rst=0. The block resumes at the first clk edge after rst rises.
//  - States: IDLE, SHIFT (2-state enum).
//    - IDLE: data_ready=1.
//      - Accept (data_valid & data_ready): shift_reg<=data_in,
//        cnt<=WIDTH-1, go to SHIFT.
//    - SHIFT, with bit_en=1 and cnt!=0: shift toward the output end, cnt<=cnt-1.
//    - SHIFT, with bit_en=1 and cnt==0:
//      - if accept: reload shift_reg and cnt, stay in SHIFT;
//      - otherwise go to IDLE.
//    - SHIFT, with bit_en=0: hold all state; bit_out is stable.
//  - data_ready = rst & (IDLE | (SHIFT & cnt==0 & bit_en)) -- combinational.
//  - bit_out: in SHIFT, shift_reg[WIDTH-1] (MSB_FIRST=1) or shift_reg[0];
//    in IDLE, IDLE_BIT. Driven combinationally from registers; no input-to-bit_out path.
//  - bit_valid = busy = (state==SHIFT). last_bit = SHIFT & cnt==0.
//  - Latency: the first bit is valid the cycle after accept. A word occupies
//    exactly WIDTH enabled cycles. Back-to-back words give continuous bit_valid.
//  - cnt is $clog2(WIDTH) bits, unsigned, and never wraps: it is reloaded or
//    cleared at 0. Vacated shift positions fill with 0.
//  - data_valid while not ready: no accept. data_in is sampled only at accept,
//    so the source may change it afterwards.
//  - rst asserted mid-word: the word is discarded immediately; no partial
//    resume after reset.
// STRUCTURE
//  - ser_pkg: state enum ser_state_t {IDLE, SHIFT}; localparam helper
//    CNT_W(WIDTH) = $clog2(WIDTH).
//  - No sub-module: one always_ff for state/shift_reg/cnt, one always_comb
//    for outputs.
// TESTING
//  1. rst=0 for 2 cycles, then release -> bit_out=0, bit_valid=0; data_ready 0
//     during reset, 1 after.
//  2. Accept 8'hA0 (MSB_FIRST), bit_en=1 -> bit_out 1,0,1,0,0,0,0,0 on 8
//     consecutive cycles; last_bit only on the 8th; then IDLE.
//  3. Accept 8'hA0 then 8'h5F on the last-bit cycle -> 16 continuous
//     bit_valid cycles; second word reads 0,1,0,1,1,1,1,1.
//  4. Toggle bit_en 1,0,0,1 mid-word -> bit_out and cnt hold through the 0s;
//     word still spans exactly 8 enabled cycles.
//  5. rst pulsed low after 3 bits of 8'hFF -> outputs go to reset values
//     asynchronously; the next accepted word starts from its bit 7.
//  6. Chain into seq_detector with 8'b1010_0000 -> seq_detected asserts after
//     the third bit is consumed.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and counter sizing for the bit serializer
package ser_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel word in, one bit per enabled clock out
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  ser_state_t state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0] cnt;
  logic accept;
  always_comb begin
    busy = state == SHIFT;
    bit_valid = busy;
    last_bit = busy && cnt == '0;
    data_ready = rst && (!busy || (last_bit && bit_en));
    accept = data_valid && data_ready;
    bit_out = busy ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_BIT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shift_reg <= '0;
      cnt <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shift_reg <= data_in;
      cnt <= CW'(WIDTH - 1);
    end else if (busy && bit_en) begin
      if (cnt != '0) begin
        shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
